// File: rtl/shim_threshold_integrator_mc.sv
// shim_threshold_integrator_mc: per-channel windowed |sample| integrator with threshold trip.
// Rev 1.0 - parametrised successor to the fixed 8-channel shim over-current integrator.
`default_nettype none

module shim_threshold_integrator_mc #(
  parameter int  NUM_CH         = 8,
  parameter int  SAMPLE_W       = 15,
  parameter int  DECIM_LOG2     = 4,
  parameter int  MAX_CHUNKS     = 16,
  parameter int  CHUNK_LOG2_MAX = 20,
  localparam int NW             = $clog2(MAX_CHUNKS) + 1
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         i_enable,
  input  logic                         i_clear,
  input  logic [4:0]                   i_chunk_log2,
  input  logic [NW-1:0]                i_num_chunks,
  input  logic [SAMPLE_W-1:0]          i_threshold_average,
  input  logic                         i_sample_core_done,
  input  logic [NUM_CH*SAMPLE_W-1:0]   i_abs_sample_concat,
  output logic                         o_setup_done,
  output logic                         o_window_full,
  output logic                         o_over_thresh,
  output logic [NUM_CH-1:0]            o_over_thresh_mask,
  output logic                         o_err_config
);

  localparam int CW  = SAMPLE_W + CHUNK_LOG2_MAX;
  localparam int TW  = CW + $clog2(MAX_CHUNKS) + 1;
  localparam int PW  = $clog2(MAX_CHUNKS);
  localparam int DW  = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam int SCW = CHUNK_LOG2_MAX;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_WAIT   = 3'd2,
    S_RUN    = 3'd3,
    S_TRIP   = 3'd4,
    S_CFGERR = 3'd5
  } state_t;

  state_t              r_state, w_next;
  logic [4:0]          r_clog2;
  logic [NW-1:0]       r_nchunks;
  logic [TW-1:0]       r_limit, r_mcand;
  logic [SAMPLE_W-1:0] r_mplier;
  logic [DW-1:0]       r_dec;
  logic [SCW-1:0]      r_samp;
  logic [PW-1:0]       r_ptr;
  logic                r_cmp_pend;
  logic                r_over, r_err, r_window_full;
  logic [NUM_CH-1:0]   r_mask;

  logic                w_cfg_bad, w_run, w_strobe, w_step, w_bound, w_dp_clr, w_ptr_last, w_trip;
  logic [SCW-1:0]      w_samp_max;
  logic [NUM_CH-1:0]   w_hit;

  assign w_cfg_bad  = (i_num_chunks == '0) || (i_num_chunks > NW'(MAX_CHUNKS)) ||
                      (i_chunk_log2 > 5'(CHUNK_LOG2_MAX));
  assign w_run      = (r_state == S_RUN) && i_enable && !i_clear;
  assign w_strobe   = (r_dec == '0);
  assign w_step     = w_run && w_strobe;
  assign w_samp_max = SCW'((32'd1 << r_clog2) - 32'd1);
  assign w_bound    = w_step && (r_samp == w_samp_max);
  assign w_ptr_last = (NW'(r_ptr) == r_nchunks - NW'(1));
  assign w_dp_clr   = i_clear || !i_enable || (r_state == S_IDLE);
  assign w_trip     = r_cmp_pend && (|w_hit);

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (i_enable) w_next = w_cfg_bad ? S_CFGERR : S_SETUP;
      S_SETUP:  if (r_mplier == '0) w_next = S_WAIT;
      S_WAIT:   if (i_sample_core_done) w_next = S_RUN;
      S_RUN:    if (w_trip) w_next = S_TRIP;
      default:  w_next = r_state;
    endcase
    if (r_state != S_IDLE && !i_enable) w_next = S_IDLE;
    if (i_clear) w_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!resetn || i_clear) begin
      r_clog2       <= '0;
      r_nchunks     <= '0;
      r_limit       <= '0;
      r_mcand       <= '0;
      r_mplier      <= '0;
      r_dec         <= '0;
      r_samp        <= '0;
      r_ptr         <= '0;
      r_cmp_pend    <= 1'b0;
      r_over        <= 1'b0;
      r_err         <= 1'b0;
      r_window_full <= 1'b0;
      r_mask        <= '0;
    end else begin
      if (r_state == S_IDLE && i_enable) begin
        r_clog2       <= i_chunk_log2;
        r_nchunks     <= i_num_chunks;
        r_limit       <= '0;
        r_mcand       <= TW'(i_num_chunks) << i_chunk_log2;
        r_mplier      <= i_threshold_average;
        r_err         <= w_cfg_bad;
        r_over        <= w_cfg_bad;
        r_mask        <= '0;
        r_window_full <= 1'b0;
      end
      // Shift-add multiply: one threshold bit per cycle, stops once no set bits remain.
      if (r_state == S_SETUP && r_mplier != '0) begin
        if (r_mplier[0]) r_limit <= r_limit + r_mcand;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
      end
      if (w_run) begin
        r_dec      <= (DECIM_LOG2 == 0) ? '0 : r_dec + DW'(1);
        r_cmp_pend <= w_bound;
        if (w_step) r_samp <= w_bound ? '0 : r_samp + SCW'(1);
        if (w_bound) begin
          r_ptr <= w_ptr_last ? '0 : r_ptr + PW'(1);
          if (w_ptr_last) r_window_full <= 1'b1;
        end
        if (w_trip) begin
          r_over <= 1'b1;
          r_mask <= w_hit;
        end
      end else begin
        r_dec      <= '0;
        r_samp     <= '0;
        r_ptr      <= '0;
        r_cmp_pend <= 1'b0;
      end
    end
  end

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [SAMPLE_W-1:0] w_x;
      logic [CW-1:0]       w_chunk, w_old, r_acc;
      logic [TW-1:0]       r_total;
      logic [CW-1:0]       r_ring [MAX_CHUNKS];

      assign w_x      = i_abs_sample_concat[(c+1)*SAMPLE_W-1 -: SAMPLE_W];
      assign w_chunk  = r_acc + CW'(w_x);
      // Once the ring has wrapped, the slot being overwritten is the chunk leaving the window.
      assign w_old    = r_window_full ? r_ring[r_ptr] : '0;
      assign w_hit[c] = (r_total > r_limit);

      always_ff @(posedge clk) begin
        if (w_bound) r_ring[r_ptr] <= w_chunk;
      end

      always_ff @(posedge clk) begin
        if (!resetn || w_dp_clr) begin
          r_acc   <= '0;
          r_total <= '0;
        end else if (w_step) begin
          if (w_bound) begin
            r_acc   <= '0;
            r_total <= r_total + TW'(w_chunk) - TW'(w_old);
          end else begin
            r_acc   <= w_chunk;
          end
        end
      end
    end
  endgenerate

  assign o_setup_done       = (r_state == S_RUN) || (r_state == S_TRIP);
  assign o_window_full      = r_window_full;
  assign o_over_thresh      = r_over;
  assign o_over_thresh_mask = r_mask;
  assign o_err_config       = r_err;

endmodule

`default_nettype wire
